dstack_spill: RTL and testbench

- Parametrised successor to the core0 data stack.
- Keeps a fixed-size register window on chip: the top plus DEPTH-1 entries below it.
- When occupancy crosses watermarks, an internal FSM automatically spills the bottom entry to a backing memory or fills it back from that memory, so the logical stack is deeper than the register file.
- Sits between the core0 execute stage and a single-port data RAM. When the window cannot serve an operation, the block stalls the core.

---
 rtl/dstack_spill.sv | 232 +++++++++++++++++++++++
 tb/tb_dstack_spill.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dstack_spill.sv
// dstack_spill: data stack with an on-chip register window and automatic
// spill/fill to a single-port backing RAM.
//
// Entry 0 is the top; entries 1..occ hold the valid words below it. When the
// window runs high the bottom entry is spilled to memory. When it runs low,
// or when an op needs more entries than the window holds, one word is filled
// back. Ops that cannot be served raise stall and must be held upstream.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   movement          00 none, 01 push, 10 pop, 11 pop twice
//   next_top          new top value, loaded on every non-stalled cycle
//   rotate, rot_addr  rotate entry[rot_addr] up to top (movement must be 00)
//   top/second/third  entries 0..2
//   rot_val           entry[rot_addr], combinational
//   stall             op not accepted this cycle
//   overflow          push dropped the bottom entry (window and memory full)
//   underflow         op needed more entries than exist; counts clear
//   occ, mem_count    valid entries below top / words held in memory
//   mem_req_*         spill write / fill read request, valid-ready
//   mem_rsp_*         fill read data
module dstack_spill #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned ROT_W    = 4,
    parameter int unsigned MEM_AW   = 10,
    parameter int unsigned SPILL_HI = DEPTH - 2,
    parameter int unsigned FILL_LO  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               movement,
    input  logic [WIDTH-1:0]         next_top,
    input  logic                     rotate,
    input  logic [ROT_W-1:0]         rot_addr,
    output logic [WIDTH-1:0]         top,
    output logic [WIDTH-1:0]         second,
    output logic [WIDTH-1:0]         third,
    output logic [WIDTH-1:0]         rot_val,
    output logic                     stall,
    output logic                     overflow,
    output logic                     underflow,
    output logic [$clog2(DEPTH)-1:0] occ,
    output logic [MEM_AW:0]          mem_count,
    output logic                     mem_req_valid,
    output logic                     mem_req_write,
    output logic [MEM_AW-1:0]        mem_req_addr,
    output logic [WIDTH-1:0]         mem_req_wdata,
    input  logic                     mem_req_ready,
    input  logic                     mem_rsp_valid,
    input  logic [WIDTH-1:0]         mem_rsp_rdata
);

    localparam int unsigned OW = $clog2(DEPTH);
    localparam logic [OW-1:0] OccMax = OW'(DEPTH - 1);
    localparam logic [OW-1:0] OccOne = OW'(1);
    localparam logic [OW-1:0] OccTwo = OW'(2);
    localparam logic [MEM_AW:0] CntOne = {{MEM_AW{1'b0}}, 1'b1};
    localparam logic [MEM_AW:0] MemCap = {1'b1, {MEM_AW{1'b0}}};

    typedef enum logic [1:0] {StIdle, StSpill, StFillReq, StFillWait} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] entry_q [DEPTH];
    logic [WIDTH-1:0] entry_d [DEPTH];
    logic [OW-1:0]    occ_q, occ_d;
    logic [MEM_AW:0]  cnt_q, cnt_d;

    logic        is_push, is_pop, is_pop2, is_rot, op_valid, op_accept;
    logic [31:0] need, occ_w, avail;
    logic        fsm_idle, mem_full, win_full, short_win, no_data, push_wait;
    logic [OW-1:0] fill_idx, rot_idx;

    // Op decode and acceptance
    assign is_push  = movement == 2'b01;
    assign is_pop   = movement == 2'b10;
    assign is_pop2  = movement == 2'b11;
    assign is_rot   = (movement == 2'b00) && rotate;
    assign op_valid = (movement != 2'b00) || rotate;

    assign need = is_pop  ? 32'd1 :
                  is_pop2 ? 32'd2 :
                  is_rot  ? 32'(rot_addr) : 32'd0;

    assign occ_w     = 32'(occ_q);
    assign avail     = occ_w + 32'(cnt_q);
    assign short_win = need > occ_w;
    assign no_data   = need > avail;
    assign fsm_idle  = state_q == StIdle;
    assign mem_full  = cnt_q == MemCap;
    assign win_full  = occ_q == OccMax;
    // A push into a full window waits for a spill unless memory is full too.
    assign push_wait = is_push && win_full && !mem_full;

    assign stall     = op_valid && (!fsm_idle || push_wait || (short_win && !no_data));
    assign underflow = op_valid && fsm_idle && no_data;
    assign overflow  = fsm_idle && is_push && win_full && mem_full;
    assign op_accept = op_valid && !stall;

    assign fill_idx = occ_q + OccOne;
    assign rot_idx  = OW'(rot_addr);

    // Next state: accepted ops take priority; the FSM only moves otherwise.
    always_comb begin
        state_d = state_q;
        occ_d   = occ_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
        end
        if (!stall) begin
            entry_d[0] = next_top;
        end

        if (op_accept) begin
            if (is_push) begin
                for (int i = 1; i < DEPTH; i++) begin
                    entry_d[i] = entry_q[i-1];
                end
            end else if (is_pop) begin
                for (int i = 1; i < DEPTH - 1; i++) begin
                    entry_d[i] = entry_q[i+1];
                end
            end else if (is_pop2) begin
                for (int i = 1; i < DEPTH - 2; i++) begin
                    entry_d[i] = entry_q[i+2];
                end
            end else begin
                for (int i = 1; i < DEPTH; i++) begin
                    if (i <= 32'(rot_addr)) begin
                        entry_d[i] = entry_q[i-1];
                    end
                end
            end

            if (underflow) begin
                occ_d = '0;
                cnt_d = '0;
            end else if (is_push) begin
                // On overflow the bottom entry falls off and occ stays put.
                if (!win_full) begin
                    occ_d = occ_q + OccOne;
                end
            end else if (is_pop) begin
                occ_d = occ_q - OccOne;
            end else if (is_pop2) begin
                occ_d = occ_q - OccTwo;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    // A stalled op that needs deeper entries also triggers a
                    // fill, so a deep rotate cannot wait forever.
                    if (occ_w > SPILL_HI && !mem_full) begin
                        state_d = StSpill;
                    end else if (cnt_q != '0 &&
                                 (occ_w < FILL_LO || (op_valid && short_win))) begin
                        state_d = StFillReq;
                    end
                end
                StSpill: begin
                    if (mem_req_ready) begin
                        occ_d   = occ_q - OccOne;
                        cnt_d   = cnt_q + CntOne;
                        state_d = StIdle;
                    end
                end
                StFillReq: begin
                    if (mem_req_ready) begin
                        state_d = StFillWait;
                    end
                end
                StFillWait: begin
                    if (mem_rsp_valid) begin
                        entry_d[fill_idx] = mem_rsp_rdata;
                        occ_d   = occ_q + OccOne;
                        cnt_d   = cnt_q - CntOne;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Memory request outputs depend on state only, so they hold until ready.
    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        case (state_q)
            StSpill: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                mem_req_addr  = cnt_q[MEM_AW-1:0];
                mem_req_wdata = entry_q[occ_q];
            end
            StFillReq: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = cnt_q[MEM_AW-1:0] - MEM_AW'(1);
            end
            default: ;
        endcase
    end

    // Only the top is reset; lower entries are qualified by occ.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            occ_q      <= '0;
            cnt_q      <= '0;
            entry_q[0] <= '0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            cnt_q      <= cnt_d;
            entry_q[0] <= entry_d[0];
        end
        for (int i = 1; i < DEPTH; i++) begin
            entry_q[i] <= entry_d[i];
        end
    end

    assign top       = entry_q[0];
    assign second    = entry_q[1];
    assign third     = entry_q[2];
    assign rot_val   = entry_q[rot_idx];
    assign occ       = occ_q;
    assign mem_count = cnt_q;

endmodule

// File: tb/tb_dstack_spill.sv
// Self-checking bench for dstack_spill (DEPTH=8, MEM_AW=3). Expected memory
// requests are queued as stimulus is applied and compared as the DUT issues
// them; the backing memory answers reads two cycles after the handshake.
module tb_dstack_spill;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ROT_W  = 3;
    localparam int unsigned MEM_AW = 3;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [1:0]               movement;
    logic [WIDTH-1:0]         next_top;
    logic                     rotate;
    logic [ROT_W-1:0]         rot_addr;
    logic [WIDTH-1:0]         top, second, third, rot_val;
    logic                     stall, overflow, underflow;
    logic [$clog2(DEPTH)-1:0] occ;
    logic [MEM_AW:0]          mem_count;
    logic                     mem_req_valid, mem_req_write;
    logic [MEM_AW-1:0]        mem_req_addr;
    logic [WIDTH-1:0]         mem_req_wdata;
    logic                     mem_req_ready, mem_rsp_valid;
    logic [WIDTH-1:0]         mem_rsp_rdata;

    always #5 clk = ~clk;

    dstack_spill #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .ROT_W   (ROT_W),
        .MEM_AW  (MEM_AW),
        .SPILL_HI(6),
        .FILL_LO (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .movement     (movement),
        .next_top     (next_top),
        .rotate       (rotate),
        .rot_addr     (rot_addr),
        .top          (top),
        .second       (second),
        .third        (third),
        .rot_val      (rot_val),
        .stall        (stall),
        .overflow     (overflow),
        .underflow    (underflow),
        .occ          (occ),
        .mem_count    (mem_count),
        .mem_req_valid(mem_req_valid),
        .mem_req_write(mem_req_write),
        .mem_req_addr (mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_rdata(mem_rsp_rdata)
    );

    typedef struct packed {
        logic              wr;
        logic [MEM_AW-1:0] addr;
        logic [WIDTH-1:0]  data;
    } req_t;

    req_t              exp_q[$];
    logic [WIDTH-1:0]  mem [1 << MEM_AW];
    logic [MEM_AW-1:0] rd_addr;
    int                lat;
    int                n_vec;
    int                n_err;
    logic              held;
    int                v;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic wr, input logic [MEM_AW-1:0] addr,
                            input logic [WIDTH-1:0] data);
        req_t e;
        e.wr   = wr;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Apply inputs just after the falling edge, then let them settle.
    task automatic drive(input logic [1:0] mv, input logic [WIDTH-1:0] nt,
                         input logic rot, input logic [ROT_W-1:0] ra);
        @(negedge clk);
        movement = mv;
        next_top = nt;
        rotate   = rot;
        rot_addr = ra;
        if (lat > 0) begin
            lat--;
            mem_rsp_valid = (lat == 0);
            mem_rsp_rdata = mem[rd_addr];
        end else begin
            mem_rsp_valid = 1'b0;
        end
        #1;
    endtask

    // Score any request handshaking on the coming edge, then step past it.
    task automatic adv();
        req_t e;
        if (!reset && mem_req_valid && mem_req_ready) begin
            check_eq("req_queued", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("req_write", 64'(mem_req_write), 64'(e.wr));
                check_eq("req_addr", 64'(mem_req_addr), 64'(e.addr));
                if (e.wr) begin
                    check_eq("req_wdata", 64'(mem_req_wdata), 64'(e.data));
                end
            end
            if (mem_req_write) begin
                mem[mem_req_addr] = mem_req_wdata;
            end else begin
                rd_addr = mem_req_addr;
                lat     = 2;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [1:0] mv, input logic [WIDTH-1:0] nt,
                        input logic rot, input logic [ROT_W-1:0] ra);
        drive(mv, nt, rot, ra);
        adv();
    endtask

    task automatic idle(input logic [WIDTH-1:0] nt);
        step(2'b00, nt, 1'b0, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run still active at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec         = 0;
        n_err         = 0;
        lat           = 0;
        rd_addr       = '0;
        reset         = 1'b1;
        movement      = 2'b00;
        next_top      = '0;
        rotate        = 1'b0;
        rot_addr      = '0;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_occ", 64'(occ), 0);
        check_eq("rst_mem_count", 64'(mem_count), 0);
        check_eq("rst_top", 64'(top), 0);
        check_eq("rst_req_valid", 64'(mem_req_valid), 0);
        check_eq("rst_req_write", 64'(mem_req_write), 0);
        check_eq("rst_req_addr", 64'(mem_req_addr), 0);
        check_eq("rst_req_wdata", 64'(mem_req_wdata), 0);
        check_eq("rst_stall", 64'(stall), 0);
        check_eq("rst_overflow", 64'(overflow), 0);
        check_eq("rst_underflow", 64'(underflow), 0);
        reset = 1'b0;

        // Load 1 into top, then push 2..7: the stack holds 1..7, occ=6.
        idle(32'd1);
        for (int k = 2; k <= 7; k++) begin
            drive(2'b01, WIDTH'(k), 1'b0, '0);
            check_eq("push_stall", 64'(stall), 0);
            adv();
        end
        check_eq("p7_occ", 64'(occ), 6);
        check_eq("p7_top", 64'(top), 7);
        check_eq("p7_second", 64'(second), 6);
        check_eq("p7_third", 64'(third), 5);
        check_eq("p7_faults", 64'({overflow, underflow}), 0);
        check_eq("p7_mem_count", 64'(mem_count), 0);

        // Eighth push fills the window; the bottom word (1) spills to addr 0.
        push_exp(1'b1, 3'd0, 32'd1);
        step(2'b01, 32'd8, 1'b0, '0);
        check_eq("p8_occ", 64'(occ), 7);
        for (int i = 0; i < 10 && mem_count == 0; i++) idle(32'd8);
        check_eq("spill_mem_count", 64'(mem_count), 1);
        check_eq("spill_occ", 64'(occ), 6);

        // Pop down to occ=1, which triggers a fill of addr 0.
        for (int k = 7; k >= 3; k--) step(2'b10, WIDTH'(k), 1'b0, '0);
        check_eq("pop_occ", 64'(occ), 1);
        check_eq("pop_top", 64'(top), 3);
        push_exp(1'b0, 3'd0, 32'd0);
        idle(32'd3);
        check_eq("fillreq_valid", 64'(mem_req_valid), 1);
        check_eq("fillreq_write", 64'(mem_req_write), 0);
        idle(32'd3);
        drive(2'b10, 32'd2, 1'b0, '0);
        check_eq("fillwait_stall", 64'(stall), 1);
        adv();
        check_eq("fillwait_top", 64'(top), 3);
        check_eq("fillwait_occ", 64'(occ), 1);
        for (int i = 0; i < 10 && occ != 2; i++) idle(32'd3);
        check_eq("fill_occ", 64'(occ), 2);
        check_eq("fill_mem_count", 64'(mem_count), 0);
        check_eq("fill_second", 64'(second), 2);
        check_eq("fill_third", 64'(third), 1);

        // Underflow: pop2 with one entry below top, then pop on an empty window.
        step(2'b10, 32'd2, 1'b0, '0);
        check_eq("pre_uf_occ", 64'(occ), 1);
        drive(2'b11, 32'h55, 1'b0, '0);
        check_eq("uf_pop2", 64'(underflow), 1);
        check_eq("uf_pop2_stall", 64'(stall), 0);
        adv();
        check_eq("uf_occ", 64'(occ), 0);
        check_eq("uf_mem_count", 64'(mem_count), 0);
        check_eq("uf_top", 64'(top), 32'h55);
        drive(2'b10, 32'h55, 1'b0, '0);
        check_eq("uf_pop", 64'(underflow), 1);
        adv();
        drive(2'b00, 32'h55, 1'b0, '0);
        check_eq("uf_clear", 64'(underflow), 0);
        adv();

        // Fill memory and window with 0x101..0x10F pushed on top of 0x55.
        push_exp(1'b1, 3'd0, 32'h55);
        for (int k = 1; k < 8; k++) push_exp(1'b1, MEM_AW'(k), 32'h100 + WIDTH'(k));
        v = 1;
        for (int i = 0; i < 200 && v <= 15; i++) begin
            drive(2'b01, 32'h100 + WIDTH'(v), 1'b0, '0);
            held = stall;
            adv();
            if (!held) v++;
        end
        check_eq("full_pushes", 64'(v), 16);
        check_eq("full_occ", 64'(occ), 7);
        check_eq("full_mem_count", 64'(mem_count), 8);
        check_eq("full_top", 64'(top), 32'h10F);
        idle(32'h10F);
        check_eq("full_no_spill", 64'(mem_req_valid), 0);
        drive(2'b01, 32'h110, 1'b0, '0);
        check_eq("ovf_flag", 64'(overflow), 1);
        check_eq("ovf_stall", 64'(stall), 0);
        adv();
        check_eq("ovf_occ", 64'(occ), 7);
        check_eq("ovf_mem_count", 64'(mem_count), 8);
        check_eq("ovf_top", 64'(top), 32'h110);
        check_eq("ovf_second", 64'(second), 32'h10F);
        check_eq("ovf_third", 64'(third), 32'h10E);
        drive(2'b00, 32'h110, 1'b0, 3'd7);
        check_eq("ovf_bottom", 64'(rot_val), 32'h109);
        adv();

        // Rotate [A=0x110, B=0x10F, C=0x10E, D=0x10D] by 3.
        drive(2'b00, 32'h10D, 1'b1, 3'd3);
        check_eq("rot_val", 64'(rot_val), 32'h10D);
        check_eq("rot_stall", 64'(stall), 0);
        adv();
        check_eq("rot_top", 64'(top), 32'h10D);
        check_eq("rot_second", 64'(second), 32'h110);
        check_eq("rot_third", 64'(third), 32'h10F);
        check_eq("rot_occ", 64'(occ), 7);

        // Drain to occ=1, start a fill of addr 7, reset while in FILL_WAIT.
        repeat (3) step(2'b11, 32'd1, 1'b0, '0);
        check_eq("drain_occ", 64'(occ), 1);
        check_eq("drain_mem_count", 64'(mem_count), 8);
        push_exp(1'b0, 3'd7, 32'd0);
        idle(32'd1);
        idle(32'd1);
        drive(2'b00, 32'd1, 1'b0, '0);
        reset = 1'b1;
        adv();
        reset = 1'b0;
        check_eq("rrst_occ", 64'(occ), 0);
        check_eq("rrst_mem_count", 64'(mem_count), 0);
        check_eq("rrst_req_valid", 64'(mem_req_valid), 0);
        check_eq("rrst_top", 64'(top), 0);
        idle(32'd1);
        check_eq("late_rsp_occ", 64'(occ), 0);
        check_eq("late_rsp_mem_count", 64'(mem_count), 0);
        check_eq("late_rsp_req_valid", 64'(mem_req_valid), 0);
        idle(32'd1);

        check_eq("queue_drained", 64'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
